uart_tx_port: RTL and testbench

//  CPU-side output peripheral: the receiving end of the CPU's port-write interface.

---
 rtl/uart_tx_port_pkg.sv | 21 ++
 rtl/uart_tx_port_if.sv | 14 +
 rtl/uart_tx_port_fifo.sv | 67 ++++++
 rtl/uart_tx_port.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_port.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_port_pkg.sv
// rtl/uart_tx_port_pkg.sv - shared FSM encodings, defaults and sizing helper for uart_tx_port
package uart_tx_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int unsigned DEFAULT_WIDTH        = 8;
    localparam int unsigned DEFAULT_DEPTH_LOG2   = 2;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

    // Bits needed for a down-counter that holds values 0..n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_port_if.sv
// rtl/uart_tx_port_if.sv - CPU port-write interface (we/wd plus status) for uart_tx_port
interface uart_tx_port_if #(
    parameter int unsigned WIDTH = 8
);
    logic             we;
    logic [WIDTH-1:0] wd;
    logic             full;
    logic             empty;
    logic             busy;
    logic             overflow;

    modport master (output we, wd, input full, empty, busy, overflow);
    modport slave  (input we, wd, output full, empty, busy, overflow);
endinterface

// File: rtl/uart_tx_port_fifo.sv
// rtl/uart_tx_port_fifo.sv - sync_fifo: small synchronous FIFO with registered full/empty
module sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  do_push, do_pop;

    always_comb begin
        do_push  = push & ~full_q;
        do_pop   = pop & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == (DEPTH_LOG2+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - CPU write port feeding a FIFO and an async serial transmitter
// Optional even-parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_port
    import uart_tx_port_pkg::*;
#(
    parameter int unsigned WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned DEPTH_LOG2   = DEFAULT_DEPTH_LOG2,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_port_if.slave   cpu,
    output logic            tx
);
    localparam int unsigned TW = cnt_width(CLKS_PER_BIT);
    localparam int unsigned BW = cnt_width(WIDTH);
    localparam logic [TW-1:0] TMAX     = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    tx_state_e        state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             timer_done;

    sync_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cpu.we),
        .pop   (fifo_pop),
        .din   (cpu.wd),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        // full is the pre-edge registered value, so a write racing a pop still counts as dropped.
        overflow_d = overflow_q | (cpu.we & fifo_full);
        timer_done = (timer_q == '0);

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_dout;
`endif
                    tx_d     = 1'b0;
                    timer_d  = TMAX;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (timer_done) begin
                    tx_d    = shift_q[0];
                    timer_d = TMAX;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (timer_done) begin
                    timer_d = TMAX;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (timer_done) begin
                    tx_d    = 1'b1;
                    timer_d = TMAX;
                    state_d = ST_STOP;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (timer_done) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx           = tx_q;
    assign cpu.full     = fifo_full;
    assign cpu.empty    = fifo_empty;
    assign cpu.busy     = busy_q;
    assign cpu.overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// tb/tb_uart_tx_port.sv - directed, table-driven bench for uart_tx_port (CLKS_PER_BIT=4, WIDTH=8)
module tb_uart_tx_port;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [7:0] wd;
        logic       par;
    } vec_t;

    logic clk;
    logic reset;
    logic tx;
    int   n_tests;
    int   n_fail;

    uart_tx_port_if #(.WIDTH(8)) cpu ();

    uart_tx_port #(
        .WIDTH        (8),
        .DEPTH_LOG2   (2),
        .CLKS_PER_BIT (C)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (cpu.slave),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_slot(input logic [7:0] d, input logic p, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        if (slot == 9 && NB == 11) return p;
        return 1'b1;
    endfunction

    // Waits for a start bit, checks every cycle of the frame, then the single idle cycle after it.
    task automatic check_frame(input string name, input logic [7:0] d, input logic p,
                               input int max_wait, output int waited);
        int errs;
        errs   = 0;
        waited = 0;
        @(negedge clk);
        while (tx !== 1'b0 && waited < max_wait) begin
            waited++;
            @(negedge clk);
        end
        if (tx !== 1'b0) begin
            check({name, "_start_timeout"}, 32'(tx), 32'(0));
            return;
        end
        for (int s = 0; s < NB; s++) begin
            for (int c = 0; c < C; c++) begin
                if (s != 0 || c != 0) @(negedge clk);
                if (tx !== exp_slot(d, p, s)) errs++;
            end
        end
        check({name, "_bits"}, 32'(errs), 32'(0));
        @(negedge clk);
        check({name, "_idle_after"}, {30'd0, cpu.busy, tx}, 32'h1);
    endtask

    vec_t vecs[10];
    int   w;
    int   bad;

    initial begin
        vecs[0] = '{8'h00, 1'b0};
        vecs[1] = '{8'hFF, 1'b0};
        vecs[2] = '{8'h01, 1'b1};
        vecs[3] = '{8'h80, 1'b1};
        vecs[4] = '{8'h55, 1'b0};
        vecs[5] = '{8'hAA, 1'b0};
        vecs[6] = '{8'h07, 1'b1};
        vecs[7] = '{8'h03, 1'b0};
        vecs[8] = '{8'hC3, 1'b0};
        vecs[9] = '{8'h7F, 1'b1};

        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        cpu.we  = 1'b0;
        cpu.wd  = 8'h00;

        // 1: reset state and quiet line
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'(1));
        check("rst_empty", 32'(cpu.empty), 32'(1));
        check("rst_full", 32'(cpu.full), 32'(0));
        check("rst_busy", 32'(cpu.busy), 32'(0));
        check("rst_overflow", 32'(cpu.overflow), 32'(0));
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        check("idle_100_tx_changes", 32'(bad), 32'(0));

        // 2: single A5 frame, start bit right after the capture edge + 1
        cpu.we = 1'b1;
        cpu.wd = 8'hA5;
        @(negedge clk);
        cpu.we = 1'b0;
        check("a5_empty_after_push", 32'(cpu.empty), 32'(0));
        check_frame("a5", 8'hA5, 1'b0, 20, w);
        check("a5_latency", 32'(w), 32'(0));

        // 3: six back-to-back writes into a 4-deep FIFO while frame 01 starts
        fork
            begin
                cpu.we = 1'b1;
                cpu.wd = 8'h01;
                for (int i = 2; i <= 6; i++) begin
                    @(negedge clk);
                    if (i == 6) check("burst_full_seen", 32'(cpu.full), 32'(1));
                    cpu.wd = 8'(i);
                end
                @(negedge clk);
                cpu.we = 1'b0;
                check("burst_overflow", 32'(cpu.overflow), 32'(1));
                check("burst_full_after", 32'(cpu.full), 32'(1));
            end
            begin
                check_frame("burst01", 8'h01, 1'b1, 20, w);
                check("burst01_latency", 32'(w), 32'(1));
            end
        join
        check_frame("burst02", 8'h02, 1'b1, 20, w);
        check("burst02_gap", 32'(w), 32'(0));
        check_frame("burst03", 8'h03, 1'b0, 20, w);
        check("burst03_gap", 32'(w), 32'(0));
        check_frame("burst04", 8'h04, 1'b1, 20, w);
        check("burst04_gap", 32'(w), 32'(0));
        check_frame("burst05", 8'h05, 1'b0, 20, w);
        check("burst05_gap", 32'(w), 32'(0));
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        check("burst_no_sixth_frame", 32'(bad), 32'(0));
        check("burst_empty_end", 32'(cpu.empty), 32'(1));
        check("burst_overflow_sticky", 32'(cpu.overflow), 32'(1));

        // 4: reset in the middle of a DATA bit, with a second word still queued
        cpu.we = 1'b1;
        cpu.wd = 8'h3C;
        @(negedge clk);
        cpu.wd = 8'h5A;
        @(negedge clk);
        cpu.we = 1'b0;
        check("abort_start_low", 32'(tx), 32'(0));
        repeat (10) @(negedge clk);
        check("abort_busy_before", 32'(cpu.busy), 32'(1));
        check("abort_queued_before", 32'(cpu.empty), 32'(0));
        #2;
        reset = 1'b1;
        #1;
        check("abort_tx", 32'(tx), 32'(1));
        check("abort_busy", 32'(cpu.busy), 32'(0));
        check("abort_empty", 32'(cpu.empty), 32'(1));
        check("abort_overflow_clr", 32'(cpu.overflow), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || cpu.busy !== 1'b0) bad++;
        end
        check("abort_no_residual", 32'(bad), 32'(0));

        // 5/6: table of single writes spaced ~50 cycles; wraps the pointers twice
        for (int i = 0; i < 10; i++) begin
            cpu.we = 1'b1;
            cpu.wd = vecs[i].wd;
            @(negedge clk);
            cpu.we = 1'b0;
            check_frame($sformatf("vec%0d_%02h", i, vecs[i].wd), vecs[i].wd, vecs[i].par, 20, w);
            check($sformatf("vec%0d_latency", i), 32'(w), 32'(0));
            repeat (8) @(negedge clk);
        end
        check("wrap_overflow", 32'(cpu.overflow), 32'(0));
        check("wrap_empty", 32'(cpu.empty), 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
